// File: rtl/isqrt_ctrl.sv
// ---------------------------------------------------------------------------
// isqrt_ctrl
// Bit-by-bit integer square root controller. Builds result = floor(sqrt(value))
// one bit at a time, MSB first. For each bit i it squares the trial guess
// (result | 1<<i) on an external pipelined multiplier and keeps the bit when
// guess^2 <= value. Only the mult_start/mult_done handshake is used, so the
// multiplier depth is irrelevant to this block.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous reset, active-low
//   start        in   request a new root (honoured in IDLE only)
//   value        in   64-bit unsigned radicand, captured on accepted start
//   mult_product in   64-bit product from the multiplier's last stage
//   mult_done    in   product-valid from the multiplier's last stage
//   mult_start   out  one-cycle launch into the multiplier's first stage
//   mult_mcand   out  64-bit multiplicand (zero-extended guess)
//   mult_mplier  out  64-bit multiplier   (zero-extended guess)
//   result       out  32-bit root, valid with done, held until next start
//   done         out  one-cycle completion pulse
//   busy         out  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module isqrt_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] value,
  input  logic [63:0] mult_product,
  input  logic        mult_done,
  output logic        mult_start,
  output logic [63:0] mult_mcand,
  output logic [63:0] mult_mplier,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q,      state_d;
  logic [63:0] value_q,      value_d;
  logic [31:0] result_q,     result_d;
  logic [4:0]  idx_q,        idx_d;
  logic [63:0] mcand_q,      mcand_d;
  logic [63:0] mplier_q,     mplier_d;
  logic        mult_start_q, mult_start_d;
  logic        done_q,       done_d;
  logic        busy_q,       busy_d;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d      = state_q;
    value_d      = value_q;
    result_d     = result_q;
    idx_d        = idx_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          value_d  = value;
          result_d = 32'd0;
          idx_d    = 5'd31;
          state_d  = S_ISSUE;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mult_done) begin
          // Keep the trial bit only if the squared guess does not overshoot.
          if (mult_product <= value_q) begin
            result_d = result_q | (32'd1 << idx_q);
          end else begin
            result_d = result_q;
          end
          if (idx_q == 5'd0) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q - 5'd1;
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // ISSUE is only ever entered from another state, so this loads the
    // operands exactly once per iteration using the updated result/index.
    if (state_d == S_ISSUE) begin
      mcand_d  = {32'd0, result_d | (32'd1 << idx_d)};
      mplier_d = {32'd0, result_d | (32'd1 << idx_d)};
    end else begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
    end

    // Outputs are decoded from the next state so they line up with it.
    mult_start_d = (state_d == S_ISSUE);
    done_d       = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      value_q      <= 64'd0;
      result_q     <= 32'd0;
      idx_q        <= 5'd31;
      mcand_q      <= 64'd0;
      mplier_q     <= 64'd0;
      mult_start_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      value_q      <= value_d;
      result_q     <= result_d;
      idx_q        <= idx_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      mult_start_q <= mult_start_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign mult_start  = mult_start_q;
  assign mult_mcand  = mcand_q;
  assign mult_mplier = mplier_q;
  assign result      = result_q;
  assign done        = done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_isqrt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_isqrt_ctrl
// Directed bench for isqrt_ctrl driven through an 8-stage multiplier model.
// Cycle numbering: the edge that samples start is cycle 0; values seen after
// edge n are reported as cycle n (so the first ISSUE is cycle 1, done 289).
// ---------------------------------------------------------------------------
module tb_isqrt_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic [63:0] value;
  logic [63:0] mult_product;
  logic        mult_done;
  logic        mult_start;
  logic [63:0] mult_mcand;
  logic [63:0] mult_mplier;
  logic [31:0] result;
  logic        done;
  logic        busy;

  int n_cmp;
  int n_err;

  isqrt_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .value       (value),
    .mult_product(mult_product),
    .mult_done   (mult_done),
    .mult_start  (mult_start),
    .mult_mcand  (mult_mcand),
    .mult_mplier (mult_mplier),
    .result      (result),
    .done        (done),
    .busy        (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // 8-stage multiplier model: done/product appear 8 cycles after mult_start.
  // Deliberately not reset so in-flight products survive a controller reset.
  logic [7:0]  pv;
  logic [63:0] pp [8];
  initial pv = 8'd0;
  always @(posedge clock) begin
    pv    <= {pv[6:0], mult_start};
    pp[0] <= mult_mcand * mult_mplier;
    for (int k = 1; k < 8; k++) pp[k] <= pp[k-1];
  end
  assign mult_done    = pv[7];
  assign mult_product = pp[7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Runs one operation and checks timing, pulse count, busy and result.
  // Entered at a negedge-aligned point; second-start injected at cycle sc.
  task automatic do_op(input string nm, input logic [63:0] v, input logic [31:0] exp,
                       input bit rel_reset, input int sc, input logic [63:0] v2);
    int   cyc;
    int   pulses;
    int   done_cyc;
    bit   busy_ok;
    bit   got_done;
    logic [63:0] first_mc;
    logic [63:0] first_mp;
    cyc = 0; pulses = 0; done_cyc = -1; busy_ok = 1'b1; got_done = 1'b0;
    first_mc = 64'd0; first_mp = 64'd0;
    @(negedge clock);
    if (rel_reset) reset = 1'b1;
    start = 1'b1;
    value = v;
    while (!got_done && cyc < 400) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (cyc == sc) begin
        start = 1'b1;
        value = v2;
      end else begin
        start = 1'b0;
        value = 64'd0;
      end
      if (mult_start) pulses++;
      if (cyc == 1) begin
        first_mc = mult_mcand;
        first_mp = mult_mplier;
      end
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end
    end
    start = 1'b0;
    check({nm, " done_cycle"}, 64'(done_cyc), 64'd289);
    check({nm, " result"}, {32'd0, result}, {32'd0, exp});
    check({nm, " mult_start_pulses"}, 64'(pulses), 64'd32);
    check({nm, " busy_throughout"}, {63'd0, busy_ok}, 64'd1);
    check({nm, " first_mcand"}, first_mc, 64'h0000_0000_8000_0000);
    check({nm, " first_mplier"}, first_mp, 64'h0000_0000_8000_0000);
    @(posedge clock);
    @(negedge clock);
    check({nm, " done_one_cycle"}, {63'd0, done}, 64'd0);
    check({nm, " idle_busy"}, {63'd0, busy}, 64'd0);
    check({nm, " result_held"}, {32'd0, result}, {32'd0, exp});
  endtask

  typedef struct {
    string       nm;
    logic [63:0] v;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int cyc;
    bit saw_done;
    n_cmp = 0;
    n_err = 0;

    vecs[0] = '{"v0",      64'd0,                     32'h0000_0000};
    vecs[1] = '{"v16",     64'd16,                    32'd4};
    vecs[2] = '{"v15",     64'd15,                    32'd3};
    vecs[3] = '{"v17",     64'd17,                    32'd4};
    vecs[4] = '{"vmax",    64'hFFFF_FFFF_FFFF_FFFF,   32'hFFFF_FFFF};
    vecs[5] = '{"vsq",     64'hFFFF_FFFE_0000_0001,   32'hFFFF_FFFF};
    vecs[6] = '{"vsq_m1",  64'hFFFF_FFFE_0000_0000,   32'hFFFF_FFFE};
    vecs[7] = '{"v1",      64'd1,                     32'd1};

    reset = 1'b0;
    start = 1'b0;
    value = 64'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst busy",       {63'd0, busy},       64'd0);
    check("rst done",       {63'd0, done},       64'd0);
    check("rst mult_start", {63'd0, mult_start}, 64'd0);
    check("rst result",     {32'd0, result},     64'd0);
    check("rst mcand",      mult_mcand,          64'd0);
    check("rst mplier",     mult_mplier,         64'd0);

    // First op releases reset and asserts start on the same edge.
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].nm, vecs[i].v, vecs[i].exp, (i == 0), -1, 64'd0);
    end

    // Second start mid-operation must be ignored.
    do_op("restart_ignored", 64'd100, 32'd10, 1'b0, 50, 64'd4);

    // Mid-operation reset: abort, no done pulse, then a clean new op.
    @(negedge clock);
    start = 1'b1;
    value = 64'd100;
    cyc = 0;
    while (cyc < 39) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      start = 1'b0;
    end
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    check("midrst busy",       {63'd0, busy},       64'd0);
    check("midrst mult_start", {63'd0, mult_start}, 64'd0);
    check("midrst done",       {63'd0, done},       64'd0);
    check("midrst result",     {32'd0, result},     64'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (done || busy) saw_done = 1'b1;
    end
    check("midrst no_done_or_busy", {63'd0, saw_done}, 64'd0);
    do_op("after_reset_v81", 64'd81, 32'd9, 1'b0, -1, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
